read_data_dispatcher: RTL and testbench

READ_DATA_DISPATCHER -- requirements
Module: read_data_dispatcher

---
 rtl/read_data_dispatcher.sv | 120 ++++++++++++
 tb/tb_read_data_dispatcher.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/read_data_dispatcher.sv
// Routes backend read beats to the core named by the core-number FIFO head, one beat per cycle.
// Optional build macro DISPATCH_UNDERFLOW_CHECK_EN: drop beats that arrive with no FIFO entry and flag them.
module read_data_dispatcher #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_CORES  = 4
) (
  input  logic                                               i_clk,
  input  logic                                               i_rst_n,
  input  logic                                               i_rdata_valid,
  input  logic [DATA_WIDTH-1:0]                              i_rdata,
  output logic                                               o_rdata_ready,
  input  logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] i_core_num,
  input  logic                                               i_fifo_empty,
  output logic                                               o_fifo_rd_en,
  output logic [NUM_CORES-1:0]                               o_core_valid,
  input  logic [NUM_CORES-1:0]                               i_core_ready,
  output logic [DATA_WIDTH-1:0]                              o_core_data,
`ifdef DISPATCH_UNDERFLOW_CHECK_EN
  output logic                                               o_underflow_err,
`endif
  output logic [15:0]                                        o_beat_cnt
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  typedef logic [CORE_W-1:0] core_num_t;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state_q,    state_d;
  logic [DATA_WIDTH-1:0] r_data_q,   r_data_d;
  core_num_t             r_core_q,   r_core_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;

  logic core_rdy;
  logic deliver;
  logic ready;
  logic accept;
  logic pop;

  always_comb begin
    core_rdy = i_core_ready[r_core_q];
    deliver  = (state_q == SEND) && core_rdy;

    // The output register frees up in the same cycle it is delivered, so a new beat may follow directly.
    ready = !i_fifo_empty && ((state_q == IDLE) || core_rdy);
`ifdef DISPATCH_UNDERFLOW_CHECK_EN
    ready = ready || ((state_q == IDLE) && i_fifo_empty);
`endif
    ready  = ready && i_rst_n;
    accept = i_rdata_valid && ready;
    pop    = accept && !i_fifo_empty;

    o_rdata_ready = ready;
    o_fifo_rd_en  = pop;
  end

  always_comb begin
    state_d    = state_q;
    r_data_d   = r_data_q;
    r_core_d   = r_core_q;
    beat_cnt_d = beat_cnt_q;

    if (deliver) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end

    if (pop) begin
      state_d  = SEND;
      r_data_d = i_rdata;
      r_core_d = i_core_num;
    end else if (deliver) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      r_data_q   <= '0;
      r_core_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      r_data_q   <= r_data_d;
      r_core_q   <= r_core_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef DISPATCH_UNDERFLOW_CHECK_EN
  logic underflow_err_q, underflow_err_d;

  always_comb begin
    underflow_err_d = underflow_err_q || (accept && i_fifo_empty);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      underflow_err_q <= 1'b0;
    end else begin
      underflow_err_q <= underflow_err_d;
    end
  end

  assign o_underflow_err = underflow_err_q;
`endif

  // Valid is decoded from the registered state so reset removes it immediately.
  always_comb begin
    o_core_valid = '0;
    if (state_q == SEND) begin
      o_core_valid[r_core_q] = 1'b1;
    end
  end

  assign o_core_data = r_data_q;
  assign o_beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_read_data_dispatcher.sv
// Directed bench for read_data_dispatcher: a cycle-by-cycle vector table plus reset and wrap sequences.
module tb_read_data_dispatcher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld;
  logic [127:0] rdata;
  logic         rdy_out;
  logic [1:0]   core_num;
  logic         empty;
  logic         rd_en;
  logic [3:0]   core_valid;
  logic [3:0]   core_ready;
  logic [127:0] core_data;
  logic [15:0]  beat_cnt;
`ifdef DISPATCH_UNDERFLOW_CHECK_EN
  logic         uf_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  read_data_dispatcher #(.DATA_WIDTH(128), .NUM_CORES(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rdata_valid  (vld),
    .i_rdata        (rdata),
    .o_rdata_ready  (rdy_out),
    .i_core_num     (core_num),
    .i_fifo_empty   (empty),
    .o_fifo_rd_en   (rd_en),
    .o_core_valid   (core_valid),
    .i_core_ready   (core_ready),
    .o_core_data    (core_data),
`ifdef DISPATCH_UNDERFLOW_CHECK_EN
    .o_underflow_err(uf_err),
`endif
    .o_beat_cnt     (beat_cnt)
  );

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [1:0] core;
    logic       empty;
    logic [3:0] rdy;
    logic       e_ready;
    logic       e_rden;
    logic [3:0] e_cv;
    logic [7:0] e_data;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic [1:0] c, input logic e,
                     input logic [3:0] r, input logic er, input logic erd, input logic [3:0] ecv,
                     input logic [7:0] ed, input logic [15:0] ecnt);
    vec_t t;
    t.vld = v; t.data = d; t.core = c; t.empty = e; t.rdy = r;
    t.e_ready = er; t.e_rden = erd; t.e_cv = ecv; t.e_data = ed; t.e_cnt = ecnt;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic e_rdy;
    rst_n = 1'b0; vld = 1'b0; rdata = '0; core_num = '0; empty = 1'b0; core_ready = 4'hF;

    // idle, then single beat to core 2
    add(0, 8'h00, 0, 1, 4'hF, 0, 0, 4'h0, 8'h00, 0);
    add(1, 8'hA5, 2, 0, 4'hF, 1, 1, 4'h0, 8'h00, 0);
    add(0, 8'h00, 0, 1, 4'hF, 0, 0, 4'h4, 8'hA5, 0);
    add(0, 8'h00, 0, 1, 4'hF, 0, 0, 4'h0, 8'hA5, 1);
    // back-pressure on core 1 for 5 cycles, other cores ready
    add(1, 8'h11, 1, 0, 4'hF, 1, 1, 4'h0, 8'hA5, 1);
    for (int k = 0; k < 5; k++) add(1, 8'h22, 3, 0, 4'hD, 0, 0, 4'h2, 8'h11, 1);
    add(0, 8'h00, 0, 1, 4'hF, 0, 0, 4'h2, 8'h11, 1);
    // streaming cores 0,3,1,2
    add(1, 8'h30, 0, 0, 4'hF, 1, 1, 4'h0, 8'h11, 2);
    add(1, 8'h31, 3, 0, 4'hF, 1, 1, 4'h1, 8'h30, 2);
    add(1, 8'h32, 1, 0, 4'hF, 1, 1, 4'h8, 8'h31, 3);
    add(1, 8'h33, 2, 0, 4'hF, 1, 1, 4'h2, 8'h32, 4);
    add(0, 8'h00, 0, 1, 4'hF, 0, 0, 4'h4, 8'h33, 5);
    add(0, 8'h00, 0, 1, 4'hF, 0, 0, 4'h0, 8'h33, 6);
    // beat with empty FIFO never enters SEND
    add(1, 8'h44, 1, 1, 4'hF, 0, 0, 4'h0, 8'h33, 6);
    add(1, 8'h44, 1, 1, 4'hF, 0, 0, 4'h0, 8'h33, 6);
    add(0, 8'h00, 2, 0, 4'hF, 1, 0, 4'h0, 8'h33, 6);
    // delivery only needs the addressed core's ready bit
    add(1, 8'h50, 2, 0, 4'hF, 1, 1, 4'h0, 8'h33, 6);
    add(0, 8'h00, 0, 1, 4'h4, 0, 0, 4'h4, 8'h50, 6);
    add(0, 8'h00, 0, 1, 4'h0, 0, 0, 4'h0, 8'h50, 7);

    @(negedge clk);
    vld = 1'b1; #1;
    chk("rst ready", rdy_out, 0);
    chk("rst rden", rd_en, 0);
    chk("rst cv", core_valid, 0);
    chk("rst cnt", beat_cnt, 0);
    chk("rst data", core_data, 0);
    @(negedge clk);
    rst_n = 1'b1; vld = 1'b0; empty = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      vld = tbl[i].vld; rdata = {120'h0, tbl[i].data}; core_num = tbl[i].core;
      empty = tbl[i].empty; core_ready = tbl[i].rdy;
      #1;
      e_rdy = tbl[i].e_ready;
`ifdef DISPATCH_UNDERFLOW_CHECK_EN
      if (tbl[i].e_cv == 4'h0 && tbl[i].empty) e_rdy = 1'b1;
`endif
      chk($sformatf("v%0d ready", i), rdy_out, e_rdy);
      chk($sformatf("v%0d rden", i), rd_en, tbl[i].e_rden);
      chk($sformatf("v%0d cv", i), core_valid, tbl[i].e_cv);
      chk($sformatf("v%0d data", i), core_data, {120'h0, tbl[i].e_data});
      chk($sformatf("v%0d cnt", i), beat_cnt, tbl[i].e_cnt);
    end
`ifdef DISPATCH_UNDERFLOW_CHECK_EN
    chk("uf err set", uf_err, 1);
`endif

    // reset asserted while a beat waits on core 3
    @(negedge clk);
    vld = 1'b1; rdata = 128'h55; core_num = 2'd3; empty = 1'b0; core_ready = 4'hF;
    @(negedge clk);
    rdata = 128'h66; core_num = 2'd0; core_ready = 4'h7; #1;
    chk("pre-rst cv", core_valid, 4'h8);
    chk("pre-rst ready", rdy_out, 0);
    #2 rst_n = 1'b0; #1;
    chk("mid-rst cv", core_valid, 0);
    chk("mid-rst cnt", beat_cnt, 0);
    chk("mid-rst ready", rdy_out, 0);
    chk("mid-rst rden", rd_en, 0);
    chk("mid-rst data", core_data, 0);
`ifdef DISPATCH_UNDERFLOW_CHECK_EN
    chk("mid-rst uf", uf_err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1; vld = 1'b0; empty = 1'b1; core_ready = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("post-rst cv%0d", k), core_valid, 0);
    end
    @(negedge clk);
    vld = 1'b1; rdata = 128'h77; core_num = 2'd1; empty = 1'b0; #1;
    chk("new accept rden", rd_en, 1);
    @(negedge clk);
    vld = 1'b0; empty = 1'b1; #1;
    chk("new beat cv", core_valid, 4'h2);
    chk("new beat data", core_data, 128'h77);

    // stream until the counter reads FFFF, then one more delivery wraps it
    for (int k = 0; k < 65534; k++) begin
      @(negedge clk);
      vld = 1'b1; rdata = 128'(k); core_num = 2'(k % 4); empty = 1'b0;
    end
    @(negedge clk);
    vld = 1'b0; empty = 1'b1;
    @(negedge clk); #1;
    chk("cnt ffff", beat_cnt, 16'hFFFF);
    chk("cnt ffff cv", core_valid, 0);
    @(negedge clk);
    vld = 1'b1; rdata = 128'h99; core_num = 2'd3; empty = 1'b0;
    @(negedge clk);
    vld = 1'b0; empty = 1'b1; #1;
    chk("pre-wrap cnt", beat_cnt, 16'hFFFF);
    chk("pre-wrap cv", core_valid, 4'h8);
    @(negedge clk); #1;
    chk("wrap cnt", beat_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
